// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, control
// state encoding, mux-select encodings and the bundled control-output struct.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_I_EXEC   = 4'd11,
      S_I_WB     = 4'd12,
      S_HALT     = 4'd13
   } state_t;

   // alu_op encodings, also consumed by the ALU function decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_OR    = 2'b11;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       i_or_d;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       retired;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational map from control state, latched opcode and mem_ready to every
// datapath strobe and mux select. Only FETCH strobes and MEM_WR retire see mem_ready.
module mc_output_decode
   import mips_pkg::*;
(
   input  state_t      state_i,
   input  logic [5:0]  opcode_i,
   input  logic        mem_ready_i,
   output ctrl_t       ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
            ctrl_o.ir_write  = mem_ready_i;
            ctrl_o.pc_write  = mem_ready_i;
         end
         S_DECODE: begin
            ctrl_o.alu_src_b = SRCB_IMM_SH2;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_MEM_ADDR: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = ALU_ADD;
         end
         S_MEM_RD: begin
            ctrl_o.mem_read = 1'b1;
            ctrl_o.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.reg_write  = 1'b1;
            ctrl_o.mem_to_reg = 1'b1;
            ctrl_o.retired    = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_o.mem_write = 1'b1;
            ctrl_o.i_or_d    = 1'b1;
            ctrl_o.retired   = mem_ready_i;
         end
         S_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_B;
            ctrl_o.alu_op    = ALU_FUNCT;
         end
         S_R_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = 1'b1;
            ctrl_o.retired   = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.alu_src_a     = 1'b1;
            ctrl_o.alu_op        = ALU_SUB;
            ctrl_o.pc_write_cond = 1'b1;
            ctrl_o.pc_source     = PCSRC_ALUOUT;
            ctrl_o.retired       = 1'b1;
         end
         S_JUMP: begin
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_source = PCSRC_JUMP;
            ctrl_o.retired   = 1'b1;
         end
         S_I_EXEC: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
            ctrl_o.alu_op    = (opcode_i == OP_ORI) ? ALU_OR : ALU_ADD;
         end
         S_I_WB: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.retired   = 1'b1;
         end
         S_HALT: begin
            ctrl_o.illegal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle core: state register, opcode latch,
// next-state sequencing with memory stalls, and the retired-instruction counter.
module multicycle_control
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        i_or_d,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        retired,
   output logic [31:0] retire_count,
   output logic        illegal,
   output logic [3:0]  state
);

   state_t      state_q, state_d;
   logic [5:0]  opcode_q, opcode_d;
   logic [31:0] retire_count_q, retire_count_d;
   ctrl_t       ctrl;

   mc_output_decode u_decode (
      .state_i     (state_q),
      .opcode_i    (opcode_q),
      .mem_ready_i (mem_ready),
      .ctrl_o      (ctrl)
   );

   always_comb begin
      state_d        = state_q;
      opcode_d       = opcode_q;
      retire_count_d = retire_count_q + {31'd0, ctrl.retired};
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            opcode_d = opcode;
            case (opcode)
               OP_RTYPE:        state_d = S_EXEC;
               OP_LW, OP_SW:    state_d = S_MEM_ADDR;
               OP_ADDI, OP_ORI: state_d = S_I_EXEC;
               OP_BEQ:          state_d = S_BRANCH;
               OP_J:            state_d = S_JUMP;
               default:         state_d = S_HALT;
            endcase
         end
         S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_EXEC:     state_d = S_R_WB;
         S_I_EXEC:   state_d = S_I_WB;
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_RESET;
         opcode_q       <= '0;
         retire_count_q <= '0;
      end else begin
         state_q        <= state_d;
         opcode_q       <= opcode_d;
         retire_count_q <= retire_count_d;
      end
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign ir_write      = ctrl.ir_write;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign reg_write     = ctrl.reg_write;
   assign i_or_d        = ctrl.i_or_d;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign pc_source     = ctrl.pc_source;
   assign retired       = ctrl.retired;
   assign illegal       = ctrl.illegal;
   assign retire_count  = retire_count_q;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a microprogram-style reference model
// queues the expected outputs of every cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

   localparam int S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_RD = 4,
                  S_MEM_WB = 5, S_MEM_WR = 6, S_EXEC = 7, S_R_WB = 8, S_BRANCH = 9,
                  S_JUMP = 10, S_I_EXEC = 11, S_I_WB = 12, S_HALT = 13;

   localparam logic [5:0] OPR = 6'b000000, OLW = 6'b100011, OSW = 6'b101011, OADDI = 6'b001000,
                          OORI = 6'b001101, OBEQ = 6'b000100, OJ = 6'b000010, OILL = 6'b111111;

   typedef struct packed {
      logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
      logic       i_or_d, reg_dst, mem_to_reg, alu_src_a;
      logic [1:0] alu_src_b, alu_op, pc_source;
      logic       retired, illegal;
   } ctl_t;

   typedef struct packed {
      ctl_t        ctl;
      logic [3:0]  st;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_ready = 1'b0;
   logic [5:0]  opcode = '0;
   logic        pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
   logic        i_or_d, reg_dst, mem_to_reg, alu_src_a, retired, illegal;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [31:0] retire_count;
   logic [3:0]  state;
   ctl_t        act;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .i_or_d(i_or_d), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .retired(retired),
      .retire_count(retire_count), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   assign act = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write,
                 i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                 retired, illegal};

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   ctl_t        tab[14];
   int          m_cur = S_RESET;
   logic [5:0]  m_op = '0;
   logic [31:0] m_count = '0;
   int          m_plan[$];
   logic        p_rn = 1'b0, p_rdy = 1'b0, p_ret = 1'b0;
   logic [5:0]  p_op = '0;

   // Per-state output table straight from the state descriptions
   task automatic init_table();
      for (int i = 0; i < 14; i++) tab[i] = '0;
      tab[S_FETCH].mem_read = 1'b1;      tab[S_FETCH].alu_src_b = 2'b01;
      tab[S_DECODE].alu_src_b = 2'b11;
      tab[S_MEM_ADDR].alu_src_a = 1'b1;  tab[S_MEM_ADDR].alu_src_b = 2'b10;
      tab[S_MEM_RD].mem_read = 1'b1;     tab[S_MEM_RD].i_or_d = 1'b1;
      tab[S_MEM_WB].reg_write = 1'b1;    tab[S_MEM_WB].mem_to_reg = 1'b1; tab[S_MEM_WB].retired = 1'b1;
      tab[S_MEM_WR].mem_write = 1'b1;    tab[S_MEM_WR].i_or_d = 1'b1;
      tab[S_EXEC].alu_src_a = 1'b1;      tab[S_EXEC].alu_op = 2'b10;
      tab[S_R_WB].reg_write = 1'b1;      tab[S_R_WB].reg_dst = 1'b1;      tab[S_R_WB].retired = 1'b1;
      tab[S_BRANCH].alu_src_a = 1'b1;    tab[S_BRANCH].alu_op = 2'b01;    tab[S_BRANCH].pc_write_cond = 1'b1;
      tab[S_BRANCH].pc_source = 2'b01;   tab[S_BRANCH].retired = 1'b1;
      tab[S_JUMP].pc_write = 1'b1;       tab[S_JUMP].pc_source = 2'b10;   tab[S_JUMP].retired = 1'b1;
      tab[S_I_EXEC].alu_src_a = 1'b1;    tab[S_I_EXEC].alu_src_b = 2'b10;
      tab[S_I_WB].reg_write = 1'b1;      tab[S_I_WB].retired = 1'b1;
      tab[S_HALT].illegal = 1'b1;
   endtask

   function automatic ctl_t expect_ctl(input int s, input logic [5:0] op, input logic rdy);
      ctl_t c;
      c = tab[s];
      if (s == S_FETCH) begin
         c.ir_write = rdy;
         c.pc_write = rdy;
      end
      if (s == S_MEM_WR) c.retired = rdy;
      if (s == S_I_EXEC && op == OORI) c.alu_op = 2'b11;
      return c;
   endfunction

   // Step list that follows DECODE for each opcode
   task automatic plan_for(input logic [5:0] op);
      m_plan.delete();
      case (op)
         OPR:         begin m_plan.push_back(S_EXEC); m_plan.push_back(S_R_WB); end
         OLW:         begin m_plan.push_back(S_MEM_ADDR); m_plan.push_back(S_MEM_RD); m_plan.push_back(S_MEM_WB); end
         OSW:         begin m_plan.push_back(S_MEM_ADDR); m_plan.push_back(S_MEM_WR); end
         OADDI, OORI: begin m_plan.push_back(S_I_EXEC); m_plan.push_back(S_I_WB); end
         OBEQ:        m_plan.push_back(S_BRANCH);
         OJ:          m_plan.push_back(S_JUMP);
         default:     m_plan.push_back(S_HALT);
      endcase
   endtask

   task automatic next_step();
      if (m_plan.size() > 0) m_cur = m_plan.pop_front();
      else m_cur = S_FETCH;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (p_rn) begin
         m_count = m_count + 32'(p_ret);
         if (m_cur == S_RESET) m_cur = S_FETCH;
         else if (m_cur == S_FETCH) begin
            if (p_rdy) m_cur = S_DECODE;
         end else if (m_cur == S_DECODE) begin
            m_op = p_op;
            plan_for(p_op);
            next_step();
         end else if (m_cur == S_MEM_RD || m_cur == S_MEM_WR) begin
            if (p_rdy) next_step();
         end else if (m_cur != S_HALT) next_step();
      end
   endtask

   task automatic apply(input logic rn, input logic rdy, input logic [5:0] op, input bit frc);
      exp_t e;
      rst_n = rn;
      mem_ready = rdy;
      opcode = op;
      if (!rn) begin
         m_cur = S_RESET;
         m_count = '0;
         m_plan.delete();
      end
      if (frc) begin
         force dut.retire_count_q = 32'hFFFF_FFFF;
         #1;
         release dut.retire_count_q;
         m_count = 32'hFFFF_FFFF;
      end
      e.ctl = expect_ctl(m_cur, m_op, rdy);
      e.st  = 4'(m_cur);
      e.cnt = m_count;
      exp_q.push_back(e);
      p_rn = rn; p_rdy = rdy; p_op = op; p_ret = e.ctl.retired;
   endtask

   task automatic do_reset(input int low_cycles);
      for (int i = 0; i < low_cycles; i++) begin
         tick();
         apply(1'b0, 1'($urandom), 6'($urandom), 1'b0);
      end
      tick();
      apply(1'b1, 1'($urandom), 6'($urandom), 1'b0);
   endtask

   function automatic int latency(input logic [5:0] op, input int wf, input int wm);
      case (op)
         OLW:        return 5 + wf + wm;
         OSW:        return 4 + wf + wm;
         OBEQ, OJ:   return 3 + wf;
         default:    return 4 + wf;
      endcase
   endfunction

   // Runs one instruction from its first FETCH; halt_exp selects the HALT outcome
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                            input int abort_at, input bit frc, input bit halt_exp);
      int   n = 0, cf = 0, cm = 0, want;
      logic rdy;
      bit   done = 0;
      while (!done && n < 60) begin
         tick();
         n++;
         if (m_cur == S_FETCH) begin
            rdy = (cf < wf) ? 1'b0 : 1'b1; cf++;
         end else if (m_cur == S_MEM_RD || m_cur == S_MEM_WR) begin
            rdy = (cm < wm) ? 1'b0 : 1'b1; cm++;
         end else rdy = 1'($urandom);
         if (n == abort_at) begin
            apply(1'b0, 1'b1, op, 1'b0);
            return;
         end
         apply(1'b1, rdy, (m_cur == S_DECODE) ? op : 6'($urandom), frc && n == 1);
         #1;
         if (retired === 1'b1 || illegal === 1'b1) done = 1;
      end
      want = halt_exp ? 3 + wf : latency(op, wf, wm);
      checks++;
      if (n != want || (halt_exp ? illegal !== 1'b1 : retired !== 1'b1)) begin
         failures++;
         $display("FAIL latency op=%b cycles=%0d retired=%b illegal=%b required_cycles=%0d",
                  op, n, retired, illegal, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act !== e.ctl) begin
            failures++;
            $display("FAIL ctrl t=%0t state_req=%0d got=%05h required=%05h", $time, e.st, act, e.ctl);
         end
         checks++;
         if (state !== e.st) begin
            failures++;
            $display("FAIL state t=%0t got=%0d required=%0d", $time, state, e.st);
         end
         checks++;
         if (retire_count !== e.cnt) begin
            failures++;
            $display("FAIL retire_count t=%0t got=%h required=%h", $time, retire_count, e.cnt);
         end
         if (e.ctl.retired) $display("retire state=%0d count_before=%0d t=%0t", e.st, e.cnt, $time);
      end
   end

   initial begin
      logic [5:0] ops[7];
      int         k;
      ops[0] = OPR; ops[1] = OLW; ops[2] = OSW; ops[3] = OADDI;
      ops[4] = OORI; ops[5] = OBEQ; ops[6] = OJ;
      init_table();

      do_reset(2);
      run_instr(OPR, 0, 0, 0, 1'b0, 1'b0);
      run_instr(OLW, 0, 2, 0, 1'b0, 1'b0);
      run_instr(OORI, 0, 0, 0, 1'b0, 1'b0);
      run_instr(OADDI, 0, 0, 0, 1'b0, 1'b0);
      run_instr(OBEQ, 0, 0, 0, 1'b0, 1'b0);
      run_instr(OJ, 0, 0, 0, 1'b0, 1'b0);
      run_instr(OSW, 1, 1, 0, 1'b0, 1'b0);
      run_instr(OLW, 2, 0, 0, 1'b0, 1'b0);

      // Illegal opcode: halt, then 20 cycles of toggling mem_ready
      run_instr(OILL, 0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         apply(1'b1, 1'(i), 6'($urandom), 1'b0);
      end
      #1;
      checks++;
      if (illegal !== 1'b1) begin
         failures++;
         $display("FAIL halt_hold illegal=%b required=1", illegal);
      end
      do_reset(1);

      // Counter wrap on a single jump
      run_instr(OJ, 0, 0, 0, 1'b1, 1'b0);
      run_instr(OPR, 0, 0, 0, 1'b0, 1'b0);

      // Reset while a store waits in MEM_WR
      run_instr(OSW, 0, 3, 4, 1'b0, 1'b0);
      do_reset(1);

      for (int i = 0; i < 200; i++) begin
         k = $urandom_range(0, 6);
         if ($urandom_range(0, 24) == 0) begin
            run_instr(ops[k], $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(1, 3), 1'b0, 1'b0);
            do_reset($urandom_range(0, 2));
         end else begin
            run_instr(ops[k], $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0, 1'b0);
         end
      end
      run_instr(6'b110000, 1, 0, 0, 1'b0, 1'b1);

      tick();
      apply(1'b1, 1'b1, 6'($urandom), 1'b0);
      repeat (2) @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
